// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction at a time, round-robin grant,
// registered request payload and a captured response replayed to the granted master.
module axi_mem_arbiter #(
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s0_axi_awvalid,
    input  logic [31:0] s0_axi_awaddr,
    input  logic [2:0]  s0_axi_awprot,
    output logic        s0_axi_awready,
    input  logic        s0_axi_wvalid,
    input  logic [31:0] s0_axi_wdata,
    input  logic [3:0]  s0_axi_wstrb,
    output logic        s0_axi_wready,
    output logic        s0_axi_bvalid,
    input  logic        s0_axi_bready,
    input  logic        s0_axi_arvalid,
    input  logic [31:0] s0_axi_araddr,
    input  logic [2:0]  s0_axi_arprot,
    output logic        s0_axi_arready,
    output logic        s0_axi_rvalid,
    input  logic        s0_axi_rready,
    output logic [31:0] s0_axi_rdata,
    input  logic        s1_axi_awvalid,
    input  logic [31:0] s1_axi_awaddr,
    input  logic [2:0]  s1_axi_awprot,
    output logic        s1_axi_awready,
    input  logic        s1_axi_wvalid,
    input  logic [31:0] s1_axi_wdata,
    input  logic [3:0]  s1_axi_wstrb,
    output logic        s1_axi_wready,
    output logic        s1_axi_bvalid,
    input  logic        s1_axi_bready,
    input  logic        s1_axi_arvalid,
    input  logic [31:0] s1_axi_araddr,
    input  logic [2:0]  s1_axi_arprot,
    output logic        s1_axi_arready,
    output logic        s1_axi_rvalid,
    input  logic        s1_axi_rready,
    output logic [31:0] s1_axi_rdata,
    output logic        mem_axi_awvalid,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_awready,
    output logic        mem_axi_wvalid,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_wready,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_arready,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, WR_DONE, RD_REQ, RD_RESP, RD_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gid_q, gid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awprot_q, awprot_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic [31:0] rdata_q, rdata_d;

    logic s0_wr_req, s1_wr_req, s0_req, s1_req;
    logic gnt_sel, g_wr_req, g_rd_req, pick_wr, accept;

    assign s0_wr_req = s0_axi_awvalid && s0_axi_wvalid;
    assign s1_wr_req = s1_axi_awvalid && s1_axi_wvalid;
    assign s0_req    = s0_wr_req || s0_axi_arvalid;
    assign s1_req    = s1_wr_req || s1_axi_arvalid;
    // On a tie the master that did not win last time gets the grant.
    assign gnt_sel   = (s0_req && s1_req) ? ~last_grant_q : s1_req;
    assign g_wr_req  = gnt_sel ? s1_wr_req : s0_wr_req;
    assign g_rd_req  = gnt_sel ? s1_axi_arvalid : s0_axi_arvalid;
    assign pick_wr   = g_wr_req && (WRITE_FIRST || !g_rd_req);
    // Gating with rstn keeps the combinational accept silent while reset is held.
    assign accept    = rstn && (state_q == IDLE) && (s0_req || s1_req);

    assign mem_axi_awaddr = awaddr_q;
    assign mem_axi_awprot = awprot_q;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;
    assign mem_axi_araddr = araddr_q;
    assign mem_axi_arprot = arprot_q;
    assign s0_axi_rdata   = rdata_q;
    assign s1_axi_rdata   = rdata_q;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        gid_d           = gid_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        awaddr_d        = awaddr_q;
        awprot_d        = awprot_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        araddr_d        = araddr_q;
        arprot_d        = arprot_q;
        rdata_d         = rdata_q;
        s0_axi_awready  = 1'b0;
        s0_axi_wready   = 1'b0;
        s0_axi_arready  = 1'b0;
        s0_axi_bvalid   = 1'b0;
        s0_axi_rvalid   = 1'b0;
        s1_axi_awready  = 1'b0;
        s1_axi_wready   = 1'b0;
        s1_axi_arready  = 1'b0;
        s1_axi_bvalid   = 1'b0;
        s1_axi_rvalid   = 1'b0;
        mem_axi_awvalid = 1'b0;
        mem_axi_wvalid  = 1'b0;
        mem_axi_bready  = 1'b0;
        mem_axi_arvalid = 1'b0;
        mem_axi_rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = gnt_sel;
                    gid_d        = gnt_sel;
                    if (pick_wr) begin
                        awaddr_d       = gnt_sel ? s1_axi_awaddr : s0_axi_awaddr;
                        awprot_d       = gnt_sel ? s1_axi_awprot : s0_axi_awprot;
                        wdata_d        = gnt_sel ? s1_axi_wdata  : s0_axi_wdata;
                        wstrb_d        = gnt_sel ? s1_axi_wstrb  : s0_axi_wstrb;
                        aw_done_d      = 1'b0;
                        w_done_d       = 1'b0;
                        s0_axi_awready = !gnt_sel;
                        s0_axi_wready  = !gnt_sel;
                        s1_axi_awready = gnt_sel;
                        s1_axi_wready  = gnt_sel;
                        state_d        = WR_REQ;
                    end else begin
                        araddr_d       = gnt_sel ? s1_axi_araddr : s0_axi_araddr;
                        arprot_d       = gnt_sel ? s1_axi_arprot : s0_axi_arprot;
                        s0_axi_arready = !gnt_sel;
                        s1_axi_arready = gnt_sel;
                        state_d        = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                mem_axi_awvalid = !aw_done_q;
                mem_axi_wvalid  = !w_done_q;
                aw_done_d = aw_done_q || mem_axi_awready;
                w_done_d  = w_done_q || mem_axi_wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                mem_axi_bready = 1'b1;
                if (mem_axi_bvalid) state_d = WR_DONE;
            end
            WR_DONE: begin
                s0_axi_bvalid = !gid_q;
                s1_axi_bvalid = gid_q;
                if (gid_q ? s1_axi_bready : s0_axi_bready) state_d = IDLE;
            end
            RD_REQ: begin
                mem_axi_arvalid = 1'b1;
                if (mem_axi_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                mem_axi_rready = 1'b1;
                if (mem_axi_rvalid) begin
                    rdata_d = mem_axi_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                s0_axi_rvalid = !gid_q;
                s1_axi_rvalid = gid_q;
                if (gid_q ? s1_axi_rready : s0_axi_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            awprot_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            araddr_q     <= '0;
            arprot_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            awprot_q     <= awprot_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with a small AXI4-Lite memory model on the mem_axi side.
module tb_axi_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic        s0_axi_awvalid, s0_axi_awready, s0_axi_wvalid, s0_axi_wready, s0_axi_bvalid, s0_axi_bready;
    logic        s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
    logic [31:0] s0_axi_awaddr, s0_axi_wdata, s0_axi_araddr, s0_axi_rdata;
    logic [2:0]  s0_axi_awprot, s0_axi_arprot;
    logic [3:0]  s0_axi_wstrb;
    logic        s1_axi_awvalid, s1_axi_awready, s1_axi_wvalid, s1_axi_wready, s1_axi_bvalid, s1_axi_bready;
    logic        s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
    logic [31:0] s1_axi_awaddr, s1_axi_wdata, s1_axi_araddr, s1_axi_rdata;
    logic [2:0]  s1_axi_awprot, s1_axi_arprot;
    logic [3:0]  s1_axi_wstrb;
    logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready, mem_axi_bvalid, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready, mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
    logic [2:0]  mem_axi_awprot, mem_axi_arprot;
    logic [3:0]  mem_axi_wstrb;

    int asserts = 0;
    int fails = 0;
    logic w_stall_en;
    logic [14:0] hs_all;

    assign hs_all = {s0_axi_awready, s0_axi_wready, s0_axi_arready, s0_axi_bvalid, s0_axi_rvalid,
                     s1_axi_awready, s1_axi_wready, s1_axi_arready, s1_axi_bvalid, s1_axi_rvalid,
                     mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready};

    axi_mem_arbiter #(.WRITE_FIRST(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awprot(s0_axi_awprot),
        .s0_axi_awready(s0_axi_awready), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wdata(s0_axi_wdata),
        .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wready(s0_axi_wready), .s0_axi_bvalid(s0_axi_bvalid),
        .s0_axi_bready(s0_axi_bready), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_araddr(s0_axi_araddr),
        .s0_axi_arprot(s0_axi_arprot), .s0_axi_arready(s0_axi_arready), .s0_axi_rvalid(s0_axi_rvalid),
        .s0_axi_rready(s0_axi_rready), .s0_axi_rdata(s0_axi_rdata),
        .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awprot(s1_axi_awprot),
        .s1_axi_awready(s1_axi_awready), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wdata(s1_axi_wdata),
        .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wready(s1_axi_wready), .s1_axi_bvalid(s1_axi_bvalid),
        .s1_axi_bready(s1_axi_bready), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_araddr(s1_axi_araddr),
        .s1_axi_arprot(s1_axi_arprot), .s1_axi_arready(s1_axi_arready), .s1_axi_rvalid(s1_axi_rvalid),
        .s1_axi_rready(s1_axi_rready), .s1_axi_rdata(s1_axi_rdata),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_awready(mem_axi_awready), .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wdata(mem_axi_wdata),
        .mem_axi_wstrb(mem_axi_wstrb), .mem_axi_wready(mem_axi_wready), .mem_axi_bvalid(mem_axi_bvalid),
        .mem_axi_bready(mem_axi_bready), .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_araddr(mem_axi_araddr),
        .mem_axi_arprot(mem_axi_arprot), .mem_axi_arready(mem_axi_arready), .mem_axi_rvalid(mem_axi_rvalid),
        .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata)
    );

    // Memory model: 64 words, AW/W accepted independently, B and R one cycle after acceptance.
    // With w_stall_en set, W is held off while AW is still pending.
    logic [31:0] mem [0:63];
    bit          init_done;
    logic        m_aw_got, m_w_got, m_aw_hit, m_w_hit, m_aw_n, m_w_n;
    logic [31:0] m_awaddr, m_wdata, m_wa, m_wd;
    logic [3:0]  m_wstrb, m_ws;

    assign mem_axi_awready = 1'b1;
    assign mem_axi_arready = 1'b1;
    assign mem_axi_wready  = !(w_stall_en && mem_axi_awvalid);
    assign m_aw_hit = mem_axi_awvalid && mem_axi_awready;
    assign m_w_hit  = mem_axi_wvalid && mem_axi_wready;
    assign m_aw_n   = m_aw_got || m_aw_hit;
    assign m_w_n    = m_w_got || m_w_hit;
    assign m_wa     = m_aw_hit ? mem_axi_awaddr : m_awaddr;
    assign m_wd     = m_w_hit ? mem_axi_wdata : m_wdata;
    assign m_ws     = m_w_hit ? mem_axi_wstrb : m_wstrb;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h1234_5678;
            mem[8] <= 32'h1111_1111;
            init_done <= 1'b1;
        end
        if (!rstn) begin
            mem_axi_bvalid <= 1'b0;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= 32'h0;
            m_aw_got <= 1'b0;
            m_w_got  <= 1'b0;
            m_awaddr <= 32'h0;
            m_wdata  <= 32'h0;
            m_wstrb  <= 4'h0;
        end else begin
            if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;
            if (m_aw_n && m_w_n) begin
                for (int b = 0; b < 4; b++)
                    if (m_ws[b]) mem[m_wa[7:2]][8*b +: 8] <= m_wd[8*b +: 8];
                mem_axi_bvalid <= 1'b1;
                m_aw_got <= 1'b0;
                m_w_got  <= 1'b0;
            end else begin
                m_aw_got <= m_aw_n;
                m_w_got  <= m_w_n;
                if (m_aw_hit) m_awaddr <= mem_axi_awaddr;
                if (m_w_hit) begin
                    m_wdata <= mem_axi_wdata;
                    m_wstrb <= mem_axi_wstrb;
                end
            end
            if (mem_axi_arvalid && mem_axi_arready) begin
                mem_axi_rvalid <= 1'b1;
                mem_axi_rdata  <= mem[mem_axi_araddr[7:2]];
            end else if (mem_axi_rvalid && mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
        end
    end

    task automatic clear_inputs();
        s0_axi_awvalid = 0; s0_axi_awaddr = 0; s0_axi_awprot = 0; s0_axi_wvalid = 0;
        s0_axi_wdata = 0; s0_axi_wstrb = 0; s0_axi_bready = 1; s0_axi_arvalid = 0;
        s0_axi_araddr = 0; s0_axi_arprot = 0; s0_axi_rready = 1;
        s1_axi_awvalid = 0; s1_axi_awaddr = 0; s1_axi_awprot = 0; s1_axi_wvalid = 0;
        s1_axi_wdata = 0; s1_axi_wstrb = 0; s1_axi_bready = 1; s1_axi_arvalid = 0;
        s1_axi_araddr = 0; s1_axi_arprot = 0; s1_axi_rready = 1;
        w_stall_en = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        s0_axi_arvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        asserts++;
        if (hs_all !== 15'h0) begin
            fails++; $display("FAIL reset_handshakes: got %h expected %h", hs_all, 15'h0);
        end
        asserts++;
        if ({mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_wstrb, s0_axi_rdata} !== 132'h0) begin
            fails++; $display("FAIL reset_payload: awaddr %h wdata %h araddr %h wstrb %h rdata %h expected all 0",
                              mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_wstrb, s0_axi_rdata);
        end
        s0_axi_arvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        s0_axi_arvalid = 1; s0_axi_araddr = 32'h10; #1;
        asserts++;
        if ({s0_axi_arready, s1_axi_arready} !== 2'b10) begin
            fails++; $display("FAIL read_accept: got %b expected %b", {s0_axi_arready, s1_axi_arready}, 2'b10);
        end
        @(negedge clk);
        s0_axi_arvalid = 0; #1;
        asserts++;
        if ({mem_axi_arvalid, mem_axi_araddr} !== {1'b1, 32'h10}) begin
            fails++; $display("FAIL read_mem_ar: arvalid %b araddr %h expected 1 00000010", mem_axi_arvalid, mem_axi_araddr);
        end
        @(negedge clk); #1;
        asserts++;
        if ({mem_axi_rready, s0_axi_rvalid} !== 2'b10) begin
            fails++; $display("FAIL read_resp_phase: got %b expected %b", {mem_axi_rready, s0_axi_rvalid}, 2'b10);
        end
        @(negedge clk); #1;
        asserts++;
        if ({s0_axi_rvalid, s1_axi_rvalid, s0_axi_rdata} !== {2'b10, 32'h1234_5678}) begin
            fails++; $display("FAIL read_data: rvalid0 %b rvalid1 %b rdata %h expected 1 0 12345678",
                              s0_axi_rvalid, s1_axi_rvalid, s0_axi_rdata);
        end
        @(negedge clk); #1;
        asserts++;
        if (hs_all !== 15'h0) begin
            fails++; $display("FAIL read_idle_after: got %h expected %h", hs_all, 15'h0);
        end
    endtask

    task automatic test_partial_write();
        int bcnt = 0, s0cnt = 0, first_b = -1;
        logic seen = 0;
        w_stall_en = 1;
        @(negedge clk);
        s1_axi_awvalid = 1; s1_axi_wvalid = 1; s1_axi_awaddr = 32'h20;
        s1_axi_wdata = 32'hAABB_CCDD; s1_axi_wstrb = 4'b0011; #1;
        asserts++;
        if ({s1_axi_awready, s1_axi_wready, s0_axi_awready, s0_axi_wready} !== 4'b1100) begin
            fails++; $display("FAIL wr_accept: got %b expected %b",
                              {s1_axi_awready, s1_axi_wready, s0_axi_awready, s0_axi_wready}, 4'b1100);
        end
        @(negedge clk);
        s1_axi_awvalid = 0; s1_axi_wvalid = 0; #1;
        asserts++;
        if ({mem_axi_awvalid, mem_axi_wvalid, mem_axi_awaddr, mem_axi_wdata, mem_axi_wstrb} !==
            {2'b11, 32'h20, 32'hAABB_CCDD, 4'b0011}) begin
            fails++; $display("FAIL wr_mem_req: v %b%b addr %h data %h strb %b expected 11 00000020 aabbccdd 0011",
                              mem_axi_awvalid, mem_axi_wvalid, mem_axi_awaddr, mem_axi_wdata, mem_axi_wstrb);
        end
        @(negedge clk); #1;
        asserts++;
        if ({mem_axi_awvalid, mem_axi_wvalid} !== 2'b01) begin
            fails++; $display("FAIL wr_indep_drop: got %b expected %b", {mem_axi_awvalid, mem_axi_wvalid}, 2'b01);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (s1_axi_bvalid) begin
                bcnt++;
                if (first_b < 0) first_b = i;
            end
            if (s0_axi_bvalid) s0cnt++;
        end
        asserts++;
        if (bcnt != 1 || s0cnt != 0) begin
            fails++; $display("FAIL wr_bvalid_once: s1 %0d s0 %0d cycles, expected 1 and 0", bcnt, s0cnt);
        end
        asserts++;
        if (first_b != 1) begin
            fails++; $display("FAIL wr_b_latency: got cycle %0d expected 1", first_b);
        end
        w_stall_en = 0;
        @(negedge clk);
        s1_axi_arvalid = 1; s1_axi_araddr = 32'h20;
        @(negedge clk);
        s1_axi_arvalid = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (s1_axi_rvalid) seen = 1;
        end
        asserts++;
        if (!seen || s1_axi_rdata !== 32'h1111_CCDD) begin
            fails++; $display("FAIL wr_readback: seen %b rdata %h expected 1 1111ccdd", seen, s1_axi_rdata);
        end
    endtask

    task automatic test_round_robin();
        int order [4];
        int ng = 0;
        logic both = 0;
        @(negedge clk);
        s0_axi_araddr = 32'h10; s1_axi_araddr = 32'h20;
        s0_axi_arvalid = 1; s1_axi_arvalid = 1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s0_axi_arready && s1_axi_arready) both = 1;
            if (s0_axi_arready) begin order[ng] = 0; ng++; end
            else if (s1_axi_arready) begin order[ng] = 1; ng++; end
        end
        @(negedge clk);
        s0_axi_arvalid = 0; s1_axi_arvalid = 0;
        repeat (6) @(negedge clk);
        asserts++;
        if (ng != 4 || both) begin
            fails++; $display("FAIL rr_grant_count: grants %0d both %b expected 4 0", ng, both);
        end
        for (int k = 0; k < ng; k++) begin
            asserts++;
            if (order[k] != (k % 2)) begin
                fails++; $display("FAIL rr_grant_%0d: got s%0d expected s%0d", k, order[k], k % 2);
            end
        end
    endtask

    task automatic test_same_master_rw();
        logic b_seen = 0, ar_seen = 0, ar_after_b = 0, r_seen = 0;
        @(negedge clk);
        s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_awaddr = 32'h30;
        s0_axi_wdata = 32'hCAFE_F00D; s0_axi_wstrb = 4'hF;
        s0_axi_arvalid = 1; s0_axi_araddr = 32'h30; #1;
        asserts++;
        if ({s0_axi_awready, s0_axi_wready, s0_axi_arready} !== 3'b110) begin
            fails++; $display("FAIL rw_write_first: got %b expected %b",
                              {s0_axi_awready, s0_axi_wready, s0_axi_arready}, 3'b110);
        end
        @(negedge clk);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        for (int c = 0; c < 20 && !ar_seen; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s0_axi_bvalid) b_seen = 1;
            if (s0_axi_arready) begin ar_seen = 1; ar_after_b = b_seen; end
        end
        @(negedge clk);
        s0_axi_arvalid = 0;
        asserts++;
        if (!ar_seen || !ar_after_b) begin
            fails++; $display("FAIL rw_b_before_ar: ar_seen %b after_b %b expected 1 1", ar_seen, ar_after_b);
        end
        for (int c = 0; c < 10 && !r_seen; c++) begin
            @(negedge clk); #1;
            if (s0_axi_rvalid) r_seen = 1;
        end
        asserts++;
        if (!r_seen || s0_axi_rdata !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL rw_readback: seen %b rdata %h expected 1 cafef00d", r_seen, s0_axi_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic seen = 0, r1 = 0;
        @(negedge clk);
        s0_axi_rready = 0; s0_axi_arvalid = 1; s0_axi_araddr = 32'h10;
        @(negedge clk);
        s0_axi_arvalid = 0; s1_axi_arvalid = 1; s1_axi_araddr = 32'h20;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s0_axi_rvalid) seen = 1;
        end
        asserts++;
        if (!seen) begin
            fails++; $display("FAIL bp_rvalid: no s0 rvalid within budget, expected 1");
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            asserts++;
            if ({s0_axi_rvalid, s1_axi_arready, s0_axi_rdata} !== {2'b10, 32'h1234_5678}) begin
                fails++; $display("FAIL bp_hold_%0d: rvalid %b s1_arready %b rdata %h expected 1 0 12345678",
                                  k, s0_axi_rvalid, s1_axi_arready, s0_axi_rdata);
            end
        end
        @(negedge clk);
        s0_axi_rready = 1; #1;
        @(negedge clk); #1;
        asserts++;
        if ({s1_axi_arready, s0_axi_rvalid} !== 2'b10) begin
            fails++; $display("FAIL bp_s1_after: got %b expected %b", {s1_axi_arready, s0_axi_rvalid}, 2'b10);
        end
        @(negedge clk);
        s1_axi_arvalid = 0;
        for (int c = 0; c < 10 && !r1; c++) begin
            @(negedge clk); #1;
            if (s1_axi_rvalid) r1 = 1;
        end
        asserts++;
        if (!r1 || s1_axi_rdata !== 32'h1111_CCDD) begin
            fails++; $display("FAIL bp_s1_data: seen %b rdata %h expected 1 1111ccdd", r1, s1_axi_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic any_b = 0, r1 = 0;
        @(negedge clk);
        s1_axi_awvalid = 1; s1_axi_wvalid = 1; s1_axi_awaddr = 32'h24;
        s1_axi_wdata = 32'h0000_0055; s1_axi_wstrb = 4'hF;
        @(negedge clk);
        s1_axi_awvalid = 0; s1_axi_wvalid = 0;
        @(negedge clk); #1;
        asserts++;
        if (mem_axi_bready !== 1'b1) begin
            fails++; $display("FAIL rst_in_wr_resp: bready %b expected 1", mem_axi_bready);
        end
        rstn = 0; #1;
        asserts++;
        if (hs_all !== 15'h0 || {mem_axi_awaddr, mem_axi_wdata, mem_axi_wstrb} !== 68'h0) begin
            fails++; $display("FAIL rst_async_outputs: hs %h awaddr %h wdata %h wstrb %h expected all 0",
                              hs_all, mem_axi_awaddr, mem_axi_wdata, mem_axi_wstrb);
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (s0_axi_bvalid || s1_axi_bvalid) any_b = 1;
        end
        rstn = 1;
        @(negedge clk);
        s1_axi_arvalid = 1; s1_axi_araddr = 32'h20; #1;
        asserts++;
        if ({s1_axi_arready, s0_axi_arready} !== 2'b10) begin
            fails++; $display("FAIL rst_regrant: got %b expected %b", {s1_axi_arready, s0_axi_arready}, 2'b10);
        end
        @(negedge clk);
        s1_axi_arvalid = 0;
        for (int c = 0; c < 10 && !r1; c++) begin
            @(negedge clk); #1;
            if (s0_axi_bvalid || s1_axi_bvalid) any_b = 1;
            if (s1_axi_rvalid) r1 = 1;
        end
        asserts++;
        if (!r1 || s1_axi_rdata !== 32'h1111_CCDD) begin
            fails++; $display("FAIL rst_read_after: seen %b rdata %h expected 1 1111ccdd", r1, s1_axi_rdata);
        end
        asserts++;
        if (any_b) begin
            fails++; $display("FAIL rst_no_bvalid: got bvalid 1 expected 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_partial_write();
        test_round_robin();
        test_same_master_rw();
        test_backpressure();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares a single `axi_memory` instance between two requesters, e.g. the CPU instruction port and the data/DMA port. It sits between the masters and the memory's `mem_axi_*` slave port. It runs exactly one transaction at a time (one read or one write) and uses round-robin arbitration between the two masters. Payloads are registered, and responses are captured and replayed to the granted master.

## Interface
- `WRITE_FIRST`, default 1: when the granted master presents both a read and a write in the same cycle, 1 selects the write and 0 selects the read.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- In the lines below, N ∈ {0,1} and one line covers one channel of master port sN.
- `sN_axi_awvalid` / `sN_axi_awaddr` / `sN_axi_awprot`  in  1/32/3; `sN_axi_awready`  out  1  write address channel.
- `sN_axi_wvalid` / `sN_axi_wdata` / `sN_axi_wstrb`  in  1/32/4; `sN_axi_wready`  out  1  write data channel.
- `sN_axi_bvalid`  out  1; `sN_axi_bready`  in  1  write response channel.
- `sN_axi_arvalid` / `sN_axi_araddr` / `sN_axi_arprot`  in  1/32/3; `sN_axi_arready`  out  1  read address channel.
- `sN_axi_rvalid`  out  1; `sN_axi_rready`  in  1; `sN_axi_rdata`  out  32  read data channel.
- `mem_axi_awvalid`/`awaddr`/`awprot`  out  1/32/3; `mem_axi_awready`  in  1  memory write address channel.
- `mem_axi_wvalid`/`wdata`/`wstrb`  out  1/32/4; `mem_axi_wready`  in  1  memory write data channel.
- `mem_axi_bvalid`  in  1; `mem_axi_bready`  out  1  memory write response channel.
- `mem_axi_arvalid`/`araddr`/`arprot`  out  1/32/3; `mem_axi_arready`  in  1  memory read address channel.
- `mem_axi_rvalid`  in  1; `mem_axi_rready`  out  1; `mem_axi_rdata`  in  32  memory read data channel.

## Operation
- **Request definitions**
  - Write request of master N: `sN_axi_awvalid && sN_axi_wvalid`. A lone AW or a lone W is not a request.
  - Read request of master N: `sN_axi_arvalid`.
- **States:** IDLE, WR_REQ, WR_RESP, WR_DONE, RD_REQ, RD_RESP, RD_DONE.
- **IDLE**
  - Master selection: if only one master requests, that master is granted. If both request, the master ≠ `last_grant` is granted.
  - Channel selection within the granted master follows `WRITE_FIRST`.
  - On grant, in the same cycle:
    - Assert the combinational handshake to the granted master: `awready`+`wready` for a write, `arready` for a read.
    - Latch addr/prot/data/strb.
    - Update `last_grant` and the internal grant id.
    - Go to WR_REQ or RD_REQ.
- **WR_REQ**
  - Drive `mem_axi_awvalid` and `mem_axi_wvalid` from the latched values.
  - Each valid drops independently after its own handshake.
  - When both have completed (both handshakes may land in the same cycle), go to WR_RESP.
- **WR_RESP**
  - `mem_axi_bready`=1.
  - On `mem_axi_bvalid`, go to WR_DONE.
- **WR_DONE**
  - `sG_axi_bvalid`=1 for the granted master G.
  - On `sG_axi_bready`, go to IDLE.
- **RD_REQ**
  - `mem_axi_arvalid` is held until `mem_axi_arready`, then go to RD_RESP.
- **RD_RESP**
  - `mem_axi_rready`=1.
  - On `mem_axi_rvalid`, capture `mem_axi_rdata` into `rdata_q` and go to RD_DONE.
- **RD_DONE**
  - `sG_axi_rvalid`=1.
  - On `sG_axi_rready`, go to IDLE.
- **Read data fanout:** `s0_axi_rdata` and `s1_axi_rdata` are both driven from `rdata_q`. Only the granted master sees `rvalid`.
- **Non-granted master:** all of its ready/valid outputs stay 0 while it waits. It must hold its request stable per AXI.
- **Address handling:** addresses and prot pass through unmodified. There is no decode and no range check (out-of-range handling belongs to the memory).

## Timing
- **Reset (async, `rstn`=0):**
  - State=IDLE, `last_grant`=1 (so master 0 wins the first tie).
  - All `*valid`/`*ready` outputs 0; `rdata_q`, `mem_axi_awaddr`/`wdata`/`wstrb`/`araddr`/`prot` are 0.
- **Reset mid-transaction:** the transaction is dropped and no response is produced. Outputs reach their reset values immediately, without waiting for a clock edge.
- **Upstream accept:** 0 cycles. The request is accepted in the first IDLE cycle in which it is present.
- **Downstream request:** `mem_axi_*valid` rises in the cycle after the upstream accept.
- **Downstream response:** the upstream `bvalid`/`rvalid` rises in the cycle after the `mem_axi_bvalid`/`rvalid` handshake.
- **Back-to-back:**
  - After the upstream B/R handshake, the FSM is in IDLE the next cycle and can grant again then.
  - Minimum gap between grants is therefore 1 idle cycle.
  - Total occupancy per transaction is 4 cycles plus the memory latency.
- **Simultaneous requests:**
  - Both masters reading in the same IDLE cycle: one grant; the other master waits, holding its request.
  - A master that holds its request continuously is served no later than the next transaction.
- **Backpressure:** `bvalid`/`rvalid` stay high indefinitely while the master's ready is 0. `rdata_q` is stable throughout.

## Test plan
- **Single read:** memory word 4 = 0x1234_5678. s0 reads 0x10 → `s0_axi_arready` in the same cycle; `mem_axi_araddr`=0x10 the next cycle; `s0_axi_rvalid` with rdata 0x1234_5678; `s1_axi_rvalid` stays 0.
- **Partial write then read:** s1 writes 0x20, data 0xAABB_CCDD, wstrb 0b0011 over old 0x1111_1111 → `s1_axi_bvalid` once. A following s1 read of 0x20 returns 0x1111_CCDD.
- **Tie, round-robin:** s0 and s1 both hold arvalid from reset → grant order s0, s1, s0, s1. No master is granted twice in a row while the other is waiting.
- **Same-master read+write:** with `WRITE_FIRST`=1, s0 asserts AW/W and AR together → the write completes (`bvalid`) before `s0_axi_arready`. The read then returns the newly written data.
- **Backpressure:** `s0_axi_rready` held 0 for 10 cycles → `rvalid` and rdata stable for all 10. s1 has a pending request and receives no grant until the s0 handshake completes.
- **Reset mid-write:** `rstn` dropped while in WR_RESP → all outputs 0 immediately, no bvalid on any port. After release, s1 requests alone and is granted normally.
